// File: rtl/cim_seq_pkg.sv
// Shared encodings for the CIM command sequencer: opcodes, FSM states and
// the size of the macro's output-register file.
package cim_seq_pkg;
  localparam int NUM_OREG = 16;
  localparam int OREG_W   = $clog2(NUM_OREG);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_MAC   = 2'd1,
    OP_READ  = 2'd2,
    OP_CLEAR = 2'd3
  } cim_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_RSEL  = 3'd2,
    S_RCAP  = 3'd3,
    S_RSEND = 3'd4
  } state_e;
endpackage

// File: rtl/cim_seq.sv
// Command sequencer for the CIM macro: single-cycle LOAD/MAC/CLEAR strobes and
// multi-beat READ of the output-register file with a ready/valid response.
module cim_seq
  import cim_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_acc,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [4:0]        cmd_cnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              we,
  output logic              cime,
  output logic              partial_sum_e,
  output logic              reset_output_reg,
  output logic [OREG_W-1:0] output_reg,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] input_data,
  input  logic [DATA_W-1:0] cim_output,
  output logic              busy,
  output logic [4:0]        rd_count
);

  state_e  state, state_nxt;
  cim_op_e op_q;
  logic    acc_q;
  logic    accept, hs;

  // cmd_ready is gated by RESN so every output reads 0 while in reset.
  assign cmd_ready = RESN && (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign hs        = rsp_valid && rsp_ready;

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    we               = 1'b0;
    cime             = 1'b0;
    partial_sum_e    = 1'b0;
    reset_output_reg = 1'b0;
    rsp_valid        = 1'b0;
    rsp_last         = 1'b0;
    busy             = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = (cmd_op == OP_READ) ? S_RSEL : S_ISSUE;
      end
      S_ISSUE: begin
        we               = (op_q == OP_LOAD);
        cime             = (op_q == OP_MAC);
        partial_sum_e    = (op_q == OP_MAC) && acc_q;
        reset_output_reg = (op_q == OP_CLEAR);
        state_nxt        = S_IDLE;
      end
      S_RSEL:  state_nxt = S_RCAP;
      S_RCAP:  state_nxt = S_RSEND;
      S_RSEND: begin
        rsp_valid = 1'b1;
        rsp_last  = (rd_count == 5'd1);
        // rd_count==1 here means this handshake delivers the final beat
        if (hs) state_nxt = (rd_count == 5'd1) ? S_IDLE : S_RSEL;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      op_q       <= OP_LOAD;
      acc_q      <= 1'b0;
      address    <= '0;
      input_data <= '0;
      output_reg <= '0;
      rd_count   <= '0;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        op_q  <= cim_op_e'(cmd_op);
        acc_q <= cmd_acc;
        if (cmd_op == OP_READ) begin
          output_reg <= cmd_addr[OREG_W-1:0];
          rd_count   <= (cmd_cnt == 5'd0) ? 5'(NUM_OREG) : cmd_cnt;
        end else begin
          address    <= cmd_addr;
          input_data <= cmd_data;
        end
      end
      if (state == S_RCAP) rsp_data <= cim_output;
      if (hs) begin
        rd_count   <= rd_count - 5'd1;
        output_reg <= output_reg + OREG_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cim_seq.sv
// Directed + randomized bench for cim_seq with a registered CIM read model and
// a strobe log compared against expectations computed from the command stream.
module tb_cim_seq;
  import cim_seq_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0, RESN = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_acc = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [4:0]    cmd_cnt = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_last;
  logic [DW-1:0] rsp_data;
  logic          we, cime, partial_sum_e, reset_output_reg, busy;
  logic [3:0]    output_reg;
  logic [AW-1:0] address;
  logic [DW-1:0] input_data;
  logic [DW-1:0] cim_output = '0;
  logic [4:0]    rd_count;

  cim_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESN(RESN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_acc(cmd_acc),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .we(we), .cime(cime), .partial_sum_e(partial_sum_e), .reset_output_reg(reset_output_reg),
    .output_reg(output_reg), .address(address), .input_data(input_data),
    .cim_output(cim_output), .busy(busy), .rd_count(rd_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    int          kind;  // 0 write, 1 mac, 2 clear
    logic        ps;
    logic [31:0] addr;
    logic [31:0] data;
  } strobe_t;

  logic [DW-1:0] cim_mem [16];
  strobe_t       strobe_q[$];
  int            n_chk = 0, n_fail = 0, cyc = 0, t_accept = 0;

  // Macro model: one cycle of read latency from output_reg
  always @(posedge CLK) cim_output <= cim_mem[output_reg];
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESN) begin
      strobe_t s;
      chk("strobe_excl", 64'(int'(we) + int'(cime) + int'(reset_output_reg) <= 1), 64'd1);
      chk("psum_gate", 64'(partial_sum_e & ~cime), 64'd0);
      if (we || cime || reset_output_reg) begin
        s.cyc  = cyc;
        s.kind = we ? 0 : (cime ? 1 : 2);
        s.ps   = partial_sum_e;
        s.addr = address;
        s.data = input_data;
        strobe_q.push_back(s);
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic acc, input logic [31:0] addr,
                      input logic [31:0] data, input logic [4:0] cnt);
    int n = 0;
    cmd_op = op; cmd_acc = acc; cmd_addr = addr; cmd_data = data; cmd_cnt = cnt;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    chk("cmd_ready_timeout", 64'(n < 200), 64'd1);
    tick();
    t_accept = cyc;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_acc = 1'($urandom); cmd_addr = $urandom;
    cmd_data = $urandom; cmd_cnt = 5'($urandom);
  endtask

  // Expected beats come from the address wrap rule: beat i reads index (start+i) mod 16.
  task automatic do_read(input logic [3:0] start, input logic [4:0] cnt, input int mode);
    int n = (cnt == 0) ? 16 : int'(cnt);
    int got = 0, budget = 0, stall = 0;
    int sq = strobe_q.size();
    logic hold_v = 1'b0;
    logic [31:0] hold_d = '0;
    if (mode == 0) rsp_ready = 1'b1;
    send(OP_READ, 1'($urandom), {28'($urandom), start}, $urandom, cnt);
    while (got < n && budget < 2000) begin
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom % 3) != 0;
        default: rsp_ready = (stall >= 5);
      endcase
      if (hold_v) begin
        chk("stall_valid", 64'(rsp_valid), 64'd1);
        chk("stall_data", 64'(rsp_data), 64'(hold_d));
      end
      if (rsp_valid && !rsp_ready) begin
        hold_v = 1'b1; hold_d = rsp_data; stall++;
      end else hold_v = 1'b0;
      if (rsp_valid && rsp_ready) begin
        int idx = (int'(start) + got) % 16;
        chk("rd_data", 64'(rsp_data), 64'(cim_mem[idx]));
        chk("rd_last", 64'(rsp_last), 64'(got == n - 1));
        chk("rd_oreg", 64'(output_reg), 64'(idx));
        chk("rd_count", 64'(rd_count), 64'(n - got));
        got++;
      end
      tick();
      budget++;
    end
    chk("rd_beats", 64'(got), 64'(n));
    chk("rd_no_strobe", 64'(strobe_q.size()), 64'(sq));
    chk("rd_idle_ready", 64'(cmd_ready), 64'd1);
    chk("rd_idle_valid", 64'(rsp_valid), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_data"},  64'(rsp_data), 64'd0);
    chk({tag, "_last"},  64'(rsp_last), 64'd0);
    chk({tag, "_strb"},  64'({we, cime, partial_sum_e, reset_output_reg}), 64'd0);
    chk({tag, "_oreg"},  64'(output_reg), 64'd0);
    chk({tag, "_addr"},  64'(address), 64'd0);
    chk({tag, "_din"},   64'(input_data), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_rdcnt"}, 64'(rd_count), 64'd0);
  endtask

  initial begin
    int q0, w;
    logic [31:0] a1, d1, a2, d2;
    for (int i = 0; i < 16; i++) cim_mem[i] = $urandom;

    // Reset state, then acceptance on the first edge after release
    tick(); tick();
    chk_zero("rst");
    RESN = 1'b1;
    cmd_op = OP_LOAD; cmd_addr = 32'd9; cmd_data = 32'h1234; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("first_edge_we", 64'(we), 64'd1);
    chk("first_edge_addr", 64'(address), 64'd9);
    tick();

    // LOAD addr=5 data=A5A5A5A5
    send(OP_LOAD, 1'b0, 32'd5, 32'hA5A5A5A5, 5'd0);
    chk("load_we", 64'(we), 64'd1);
    chk("load_addr", 64'(address), 64'd5);
    chk("load_data", 64'(input_data), 64'hA5A5A5A5);
    chk("load_other", 64'({cime, reset_output_reg}), 64'd0);
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_ready_lo", 64'(cmd_ready), 64'd0);
    tick();
    chk("load_we_off", 64'(we), 64'd0);
    chk("load_ready_hi", 64'(cmd_ready), 64'd1);
    chk("load_addr_hold", 64'(address), 64'd5);

    // CLEAR, MAC acc=0, MAC acc=1 back-to-back
    q0 = strobe_q.size();
    a1 = $urandom; d1 = $urandom; a2 = $urandom; d2 = $urandom;
    send(OP_CLEAR, 1'b1, $urandom, $urandom, 5'd0);
    send(OP_MAC, 1'b0, a1, d1, 5'd0);
    send(OP_MAC, 1'b1, a2, d2, 5'd0);
    tick();
    chk("cm_count", 64'(strobe_q.size()), 64'(q0 + 3));
    if (strobe_q.size() == q0 + 3) begin
      chk("cm_k0", 64'(strobe_q[q0].kind), 64'd2);
      chk("cm_k1", 64'(strobe_q[q0+1].kind), 64'd1);
      chk("cm_ps1", 64'(strobe_q[q0+1].ps), 64'd0);
      chk("cm_a1", 64'({strobe_q[q0+1].addr, strobe_q[q0+1].data}), {a1, d1});
      chk("cm_k2", 64'(strobe_q[q0+2].kind), 64'd1);
      chk("cm_ps2", 64'(strobe_q[q0+2].ps), 64'd1);
      chk("cm_a2", 64'({strobe_q[q0+2].addr, strobe_q[q0+2].data}), {a2, d2});
      chk("cm_gap1", 64'(strobe_q[q0+1].cyc - strobe_q[q0].cyc), 64'd2);
      chk("cm_gap2", 64'(strobe_q[q0+2].cyc - strobe_q[q0+1].cyc), 64'd2);
    end

    // READ wrap: start 14, 3 beats, CIM returns 0x100+index
    for (int i = 0; i < 16; i++) cim_mem[i] = 32'h100 + 32'(i);
    do_read(4'd14, 5'd3, 0);

    // Backpressure: 5 stalled cycles on the first beat
    for (int i = 0; i < 16; i++) cim_mem[i] = $urandom;
    do_read(4'($urandom), 5'd2, 2);

    // Full READ: 16 beats in 48 cycles with rsp_ready high
    do_read(4'($urandom), 5'd0, 0);
    chk("full_cycles", 64'(cyc - t_accept), 64'd48);

    // Randomized LOAD/MAC traffic against the strobe log
    for (int k = 0; k < 6; k++) begin
      logic [1:0] op = ($urandom % 2) ? OP_MAC : OP_LOAD;
      logic acc = 1'($urandom);
      q0 = strobe_q.size();
      a1 = $urandom; d1 = $urandom;
      send(op, acc, a1, d1, 5'($urandom));
      tick();
      chk("rnd_count", 64'(strobe_q.size()), 64'(q0 + 1));
      if (strobe_q.size() == q0 + 1) begin
        chk("rnd_kind", 64'(strobe_q[q0].kind), (op == OP_MAC) ? 64'd1 : 64'd0);
        chk("rnd_ps", 64'(strobe_q[q0].ps), 64'((op == OP_MAC) && acc));
        chk("rnd_ad", 64'({strobe_q[q0].addr, strobe_q[q0].data}), {a1, d1});
      end
    end

    // Randomized READs with random backpressure
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 16; i++) cim_mem[i] = $urandom;
      do_read(4'($urandom), 5'($urandom_range(0, 20)), 1);
    end

    // Reset abort during RSEND of a READ cnt=4
    rsp_ready = 1'b0;
    send(OP_READ, 1'b0, 32'd3, 32'd0, 5'd4);
    w = 0;
    while (!rsp_valid && w < 20) begin tick(); w++; end
    chk("abort_reach_rsend", 64'(rsp_valid), 64'd1);
    RESN = 1'b0;
    #1;
    chk_zero("abort");
    tick();
    RESN = 1'b1;
    rsp_ready = 1'b1;
    send(OP_LOAD, 1'b0, 32'h77, 32'hCAFEF00D, 5'd0);
    chk("post_abort_we", 64'(we), 64'd1);
    chk("post_abort_ad", 64'({address, input_data}), {32'h77, 32'hCAFEF00D});
    tick();
    chk("post_abort_idle", 64'({cmd_ready, busy, rsp_valid}), 64'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cim_seq.md
CIM_SEQ -- requirements
Module: cim_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the CIM address bus.
REQ-002 SHALL have parameter DATA_W, default 32, width of the CIM input data, CIM output data and response data.
REQ-003 SHALL have ports CLK (in, 1): the single clock, rising edge; RESN (in, 1): asynchronous, active-low reset.
REQ-004 SHALL have command ports, all inputs except cmd_ready:
- cmd_valid (in, 1)
- cmd_ready (out, 1)
- cmd_op (in, 2): 0=LOAD, 1=MAC, 2=READ, 3=CLEAR
- cmd_acc (in, 1): MAC accumulate
- cmd_addr (in, ADDR_W)
- cmd_data (in, DATA_W)
- cmd_cnt (in, 5): READ count
REQ-005 SHALL have response ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_data (out, DATA_W), rsp_last (out, 1).
REQ-006 SHALL drive the CIM macro through these ports:
- we (out, 1)
- cime (out, 1)
- partial_sum_e (out, 1)
- reset_output_reg (out, 1)
- output_reg (out, 4)
- address (out, ADDR_W)
- input_data (out, DATA_W)
- cim_output (in, DATA_W)
REQ-007 SHALL have status outputs busy (out, 1) and rd_count (out, 5): the number of READ beats remaining.

Function
REQ-008 SHALL implement the FSM states IDLE, ISSUE, RSEL, RCAP and RSEND.
REQ-009 SHALL assert cmd_ready only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-010 SHALL register cmd_op, cmd_acc, cmd_addr, cmd_data and cmd_cnt on acceptance; it SHALL then ignore the cmd_* inputs until it returns to IDLE.
REQ-011 For LOAD, MAC or CLEAR, SHALL move IDLE->ISSUE->IDLE, so that each command occupies exactly 2 cycles.
REQ-012 In ISSUE for LOAD, SHALL assert we=1 for exactly one cycle, with address=cmd_addr and input_data=cmd_data.
REQ-013 In ISSUE for MAC, SHALL assert cime=1 for exactly one cycle, with partial_sum_e=cmd_acc, address=cmd_addr and input_data=cmd_data.
REQ-014 In ISSUE for CLEAR, SHALL assert reset_output_reg=1 for exactly one cycle.
REQ-015 we, cime and reset_output_reg SHALL be mutually exclusive; partial_sum_e SHALL be 0 whenever cime=0.
REQ-016 For READ, SHALL move IDLE->RSEL and load rd_count with cmd_cnt, where cmd_cnt=0 means 16 beats.
REQ-017 The starting output-register index SHALL be cmd_addr[3:0].
REQ-018 In RSEL, SHALL drive output_reg to the current index and hold that value through RCAP.
REQ-019 SHALL allow cim_output one cycle of read latency: in RCAP it SHALL capture cim_output into rsp_data, then move to RSEND.
REQ-020 In RSEND, SHALL hold rsp_valid=1 with rsp_data stable until rsp_ready=1.
REQ-021 SHALL assert rsp_last together with rsp_valid on the final beat.
REQ-022 On each handshake, SHALL decrement rd_count and increment the index modulo 16 (index 15 wraps to 0).
REQ-023 After a handshake, SHALL go to RSEL if rd_count is nonzero, otherwise to IDLE.
REQ-024 A zero-stall READ beat SHALL take 3 cycles: RSEL, RCAP, RSEND.
REQ-025 rsp_ready held low SHALL stall the sequencer indefinitely, with no loss of data and no CIM strobes.
REQ-026 When idle, SHALL drive all CIM strobes to 0; address, input_data and output_reg SHALL hold their last values.
REQ-027 busy SHALL be 1 in every state other than IDLE.
REQ-028 An undefined cmd_op cannot occur, since all 4 encodings are defined.

Reset
REQ-029 While RESN=0, SHALL hold the state at IDLE and every output at 0, including rsp_data and rd_count.
REQ-030 An assertion of RESN mid-command SHALL abort the command immediately with no further CIM strobes; a pending response SHALL be discarded.
REQ-031 SHALL accept a command on the first rising edge after RESN deasserts.

Structure
REQ-032 A shared package SHALL hold the cmd_op encodings (OP_LOAD, OP_MAC, OP_READ, OP_CLEAR), the FSM state encoding and the output-register count of 16.
REQ-033 SHALL be implemented as a single module, with no sub-modules.
REQ-034 SHALL connect to the existing CIM macro port-for-port, in place of the CPU's CIM ports.

Verification
REQ-035 LOAD scenario: LOAD addr=5, data=0xA5A5A5A5 -> one cycle of we=1, address=5, input_data=0xA5A5A5A5; cmd_ready returns high 2 cycles after acceptance.
REQ-036 CLEAR and MAC scenario: CLEAR, then MAC acc=0, then MAC acc=1, issued back-to-back -> reset_output_reg pulse, then cime with partial_sum_e=0, then cime with partial_sum_e=1; strobes are spaced 2 cycles apart and are never simultaneous.
REQ-037 READ wrap scenario: READ addr=14, cnt=3, with a CIM model returning 0x100+index -> output_reg sequence 14,15,0; rsp_data 0x10E, 0x10F, 0x100; rsp_last on the third beat only.
REQ-038 Backpressure scenario: READ cnt=2 with rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stable throughout, no CIM strobes, and exactly 2 beats delivered.
REQ-039 Full READ scenario: READ cnt=0 -> 16 beats; with rsp_ready tied high, the command takes 48 cycles after acceptance.
REQ-040 Reset-abort scenario: RESN pulsed low during RSEND of a READ cnt=4 -> all outputs 0 immediately; a LOAD issued afterwards executes normally.
